// File: rtl/sm83_sp_pkg.sv
// Shared types for the SM83 stack-pointer unit.
// Holds the micro-op codes, the sequencer states and the SP width.
package sm83_sp_pkg;

  localparam int SP_W = 16;

  typedef enum logic [3:0] {
    OP_NOP    = 4'd0,
    OP_LD_LO  = 4'd1,
    OP_LD_HI  = 4'd2,
    OP_LD_HL  = 4'd3,
    OP_INC    = 4'd4,
    OP_DEC    = 4'd5,
    OP_PUSH   = 4'd6,
    OP_POP    = 4'd7,
    OP_ADD_E8 = 4'd8
  } sp_op_t;

  typedef enum logic [1:0] {
    IDLE,
    PUSH2,
    POP2,
    ADD2
  } sp_state_t;

endpackage

// File: rtl/sm83_sp_add8.sv
// 8-bit adder with carry-in that also exposes the nibble (bit 3) carry.
// This single adder is shared by both halves of ADD SP,e8.
module sm83_sp_add8 (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] sum,
  output logic       h,
  output logic       c
);

  logic [4:0] lo_nib;
  logic [4:0] hi_nib;

  always_comb begin
    lo_nib = {1'b0, a[3:0]} + {1'b0, b[3:0]} + {4'b0000, cin};
    hi_nib = {1'b0, a[7:4]} + {1'b0, b[7:4]} + {4'b0000, lo_nib[4]};
  end

  assign sum = {hi_nib[3:0], lo_nib[3:0]};
  assign h   = lo_nib[4];
  assign c   = hi_nib[4];

endmodule

// File: rtl/sm83_sp_unit.sv
// SM83 stack-pointer register and its micro-op sequencer.
// Multi-cycle ops (PUSH, POP, ADD SP,e8) take one extra state before returning to IDLE.
module sm83_sp_unit
  import sm83_sp_pkg::*;
#(
  parameter logic [SP_W-1:0] RESET_SP = 16'h0000
) (
  input  logic            clk,
  input  logic            nreset,
  input  logic            cmd_valid,
  input  logic [3:0]      cmd_op,
  output logic            cmd_ready,
  input  logic [7:0]      d_in,
  input  logic [SP_W-1:0] hl_in,
  input  logic [7:0]      e8_in,
  output logic [SP_W-1:0] sp_out,
  output logic [SP_W-1:0] addr_out,
  output logic            addr_valid,
  output logic            addr_hi,
  output logic            done,
  output logic            flag_h,
  output logic            flag_c
);

  sp_state_t       state;
  logic [SP_W-1:0] sp;
  logic            add_c;
  logic            add_sign;

  logic [7:0] add_a;
  logic [7:0] add_b;
  logic       add_cin;
  logic [7:0] add_sum;
  logic       add_h;
  logic       add_co;

  assign cmd_ready = (state == IDLE);
  assign sp_out    = sp;

  // Low half adds e8 to SP[7:0]; high half adds the sign extension plus the saved carry.
  always_comb begin
    add_a   = sp[7:0];
    add_b   = e8_in;
    add_cin = 1'b0;
    if (state == ADD2) begin
      add_a   = sp[15:8];
      add_b   = {8{add_sign}};
      add_cin = add_c;
    end
  end

  sm83_sp_add8 u_add8 (
    .a   (add_a),
    .b   (add_b),
    .cin (add_cin),
    .sum (add_sum),
    .h   (add_h),
    .c   (add_co)
  );

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state      <= IDLE;
      sp         <= RESET_SP;
      addr_out   <= '0;
      addr_valid <= 1'b0;
      addr_hi    <= 1'b0;
      done       <= 1'b0;
      flag_h     <= 1'b0;
      flag_c     <= 1'b0;
      add_c      <= 1'b0;
      add_sign   <= 1'b0;
    end else begin
      done       <= 1'b0;
      addr_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            case (cmd_op)
              OP_LD_LO: begin
                sp[7:0] <= d_in;
                done    <= 1'b1;
              end
              OP_LD_HI: begin
                sp[15:8] <= d_in;
                done     <= 1'b1;
              end
              OP_LD_HL: begin
                sp   <= hl_in;
                done <= 1'b1;
              end
              OP_INC: begin
                sp   <= sp + 16'd1;
                done <= 1'b1;
              end
              OP_DEC: begin
                sp   <= sp - 16'd1;
                done <= 1'b1;
              end
              OP_PUSH: begin
                sp         <= sp - 16'd1;
                addr_out   <= sp - 16'd1;
                addr_hi    <= 1'b1;
                addr_valid <= 1'b1;
                state      <= PUSH2;
              end
              OP_POP: begin
                addr_out   <= sp;
                addr_hi    <= 1'b0;
                addr_valid <= 1'b1;
                sp         <= sp + 16'd1;
                state      <= POP2;
              end
              OP_ADD_E8: begin
                sp[7:0]  <= add_sum;
                flag_h   <= add_h;
                flag_c   <= add_co;
                add_c    <= add_co;
                add_sign <= e8_in[7];
                state    <= ADD2;
              end
              default: done <= 1'b1;
            endcase
          end
        end
        PUSH2: begin
          sp         <= sp - 16'd1;
          addr_out   <= sp - 16'd1;
          addr_hi    <= 1'b0;
          addr_valid <= 1'b1;
          done       <= 1'b1;
          state      <= IDLE;
        end
        POP2: begin
          addr_out   <= sp;
          addr_hi    <= 1'b1;
          addr_valid <= 1'b1;
          sp         <= sp + 16'd1;
          done       <= 1'b1;
          state      <= IDLE;
        end
        ADD2: begin
          sp[15:8] <= add_sum;
          done     <= 1'b1;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
